// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: SPI byte FIFO with a prefetched head stage feeding the DSP command input.
// Optional macro SPI_CMD_FIFO_HIGH_WATER_EN drives almost_full from HIGH_WATER.
module spi_cmd_fifo #(
  parameter int DEPTH      = 512,
  parameter int WIDTH      = 8,
  parameter int HIGH_WATER = 448
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_byte,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     clear_overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             rd_pend, pop, push, drop, rd_en;
  logic [CW-1:0]    count_nxt;
  assign pop       = out_valid && out_ready && !flush;
  assign push      = in_valid && (!full || pop) && !flush;
  assign drop      = in_valid && full && !pop && !flush;
  // entries still in RAM = count minus the head byte and any read in flight
  assign rd_en     = !flush && !rd_pend && (!out_valid || pop) &&
                     (fifo_count != CW'(out_valid) + CW'(rd_pend));
  assign count_nxt = flush ? '0 : fifo_count + CW'(push) - CW'(pop);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_byte;
    if (rd_en) rd_data <= mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_pend     <= 1'b0;
      out_valid   <= 1'b0;
      out_byte    <= '0;
      fifo_count  <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr     <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr     <= flush ? '0 : rd_ptr + AW'(rd_en);
      rd_pend    <= rd_en;
      out_valid  <= !flush && (rd_pend || (out_valid && !pop));
      if (rd_pend && !flush) out_byte <= rd_data;
      fifo_count <= count_nxt;
      full       <= count_nxt == CW'(DEPTH);
      empty      <= count_nxt == '0;
      overflow   <= drop || (overflow && !clear_overflow);
`ifdef SPI_CMD_FIFO_HIGH_WATER_EN
      almost_full <= count_nxt >= CW'(HIGH_WATER);
`else
      almost_full <= 1'b0;
`endif
    end
  end
`ifndef SPI_CMD_FIFO_HIGH_WATER_EN
  logic unused_high_water;
  assign unused_high_water = ^HIGH_WATER;
`endif
endmodule

// File: doc/spi_cmd_fifo.md
Name: spi_cmd_fifo

Overview:
Byte FIFO between the SPI slave's received-byte strobe and the DSP engine's command input. It absorbs SPI bursts while the engine is busy, then presents bytes to the engine with a valid/ready handshake. It also reports fill level and a sticky overflow flag for LEDs and debug. The buffer is a single RAM with a registered read port, all in the sys_clk domain.

Parameters:
DEPTH, 512, number of byte entries; power of two, at least 4.
WIDTH, 8, entry width in bits.
HIGH_WATER, 448, almost_full threshold in entries; used only when the optional feature is compiled in.

Ports:
clk  in  1  system clock (sys_clk).
reset_n  in  1  asynchronous active-low reset.
in_byte  in  WIDTH  byte from the SPI slave (mosi_byte).
in_valid  in  1  one-cycle write strobe (data_ready).
out_byte  out  WIDTH  head-of-FIFO byte, connects to the engine's command_in.
out_valid  out  1  out_byte holds a valid byte.
out_ready  in  1  engine can accept a byte; a pop occurs when out_valid and out_ready are both high.
flush  in  1  synchronous clear of the FIFO contents.
clear_overflow  in  1  synchronous clear of the overflow flag.
fifo_count  out  $clog2(DEPTH)+1  entries held, including the one on out_byte.
full  out  1  fifo_count equals DEPTH.
empty  out  1  fifo_count equals 0.
overflow  out  1  sticky flag: a byte was dropped.
almost_full  out  1  high-water flag (optional feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers and fifo_count go to 0.
  - out_valid=0, out_byte=0, empty=1, full=0, overflow=0, almost_full=0.
  - RAM contents are not reset.
- Pointers: write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count is a separate counter, updated +1, -1 or unchanged in the same cycle as the push/pop.
- Push condition: in_valid && (!full || pop).
  - A push into a full FIFO with a simultaneous pop is accepted; count stays DEPTH.
- Drop condition: in_valid && full && !pop.
  - The byte is discarded and overflow is set.
  - Pointers and count are unchanged.
- Head prefetch:
  - out_byte/out_valid form a registered head stage fed from the registered RAM read port.
  - A state bit tracks whether a prefetch read is in flight.
  - Write latency: a push into an empty FIFO at clock edge E gives out_valid=1, with that byte on out_byte, after edge E+2.
  - Pop throughput: after a pop at edge P, the next byte appears after edge P+1 if one is stored. Back-to-back pops therefore sustain 1 byte per 2 cycles.
  - out_valid and out_byte stay stable while out_ready is low.
- Simultaneous push and pop when fifo_count==1: the pop drains the head, and the new byte follows with the normal 2-edge latency. No byte is lost or duplicated.
- flush:
  - In the cycle it is sampled high, flush overrides push and pop.
  - Pointers, count and out_valid are cleared, and any in-flight prefetch is cancelled.
  - overflow is unaffected by flush.
- Overflow flag:
  - clear_overflow clears overflow.
  - If a drop and clear_overflow occur in the same cycle, the drop wins and overflow stays 1.
- full, empty and almost_full are registered and update on the same edge as fifo_count.

Optional Feature:
SPI_CMD_FIFO_HIGH_WATER_EN:
- Defined: almost_full is registered high whenever fifo_count >= HIGH_WATER, and low otherwise.
- Undefined: almost_full is tied to 0 and HIGH_WATER is ignored.
- The port list is identical in both builds.

Test Plan:
- Reset: hold reset_n low mid-burst with 10 bytes stored -> immediately out_valid=0, fifo_count=0, empty=1, overflow=0. After release, no stale byte appears on out_byte.
- Ordered burst: push 0x01..0x10 at one per cycle with out_ready=0, then raise out_ready -> 16 pops in order 0x01..0x10; fifo_count returns to 0 and empty=1. A first byte pushed at edge E is valid after edge E+2.
- Full and overflow (DEPTH=8):
  - Push 9 bytes with no pop -> full=1, fifo_count=8, overflow=1; the 9th byte is dropped and pops return bytes 1..8.
  - Push while full with a simultaneous pop -> accepted, count stays 8, overflow stays 0.
- Flush: with 5 bytes stored and a push asserted in the same cycle as flush -> fifo_count=0, out_valid=0, the pushed byte is discarded, and overflow keeps its prior value.
- Overflow clear race: drop and clear_overflow in the same cycle -> overflow=1. clear_overflow alone on the next cycle -> overflow=0.
- High water (macro defined, DEPTH=8, HIGH_WATER=6): 6th push -> almost_full=1; one pop -> almost_full=0. With the macro undefined -> almost_full stays 0 throughout.
